// File: rtl/arcade_input_mapper_if.sv
// Player-input bundle between the HPS front end and the input mapper.
// master: drives PS/2 key events and joystick words, reads the control lines.
// slave : the mapper; consumes events/joysticks, drives the active-low
//         per-player direction, start and coin lines.
interface arcade_input_mapper_if #(
    parameter int PLAYERS = 2
);
    logic [10:0]             ps2_key;
    logic [16*PLAYERS-1:0]   joystick;
    logic [PLAYERS-1:0]      up_n;
    logic [PLAYERS-1:0]      down_n;
    logic [PLAYERS-1:0]      left_n;
    logic [PLAYERS-1:0]      right_n;
    logic [PLAYERS-1:0]      start_n;
    logic [PLAYERS-1:0]      coin_n;

    modport master (
        output ps2_key, joystick,
        input  up_n, down_n, left_n, right_n, start_n, coin_n
    );

    modport slave (
        input  ps2_key, joystick,
        output up_n, down_n, left_n, right_n, start_n, coin_n
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Arcade player-input front end.
// Decodes PS/2 key events into per-player button latches, ORs them with the
// registered HPS joysticks, resolves opposing directions (optional), shapes
// coins into fixed-length one-shots and drives registered active-low lines.
// Ports:
//   clk_sys  system clock
//   Reset_I  synchronous active-low reset
//   bus      slave side of arcade_input_mapper_if (ps2_key, joystick in;
//            up_n/down_n/left_n/right_n/start_n/coin_n out)
//
// Coin one-shot, per player:
//   state | meaning
//   IDLE  | cnt == 0, armed: waiting for a raw coin rising edge
//   PULSE | cnt  > 0: coin_n low, counting down, edges ignored
//   WAIT  | cnt == 0, not armed: waiting for raw coin to drop before re-arming
module arcade_input_mapper #(
    parameter int PLAYERS      = 2,
    parameter int COIN_CYCLES  = 600000,
    parameter bit SOCD_NEUTRAL = 1'b1
) (
    input  logic                  clk_sys,
    input  logic                  Reset_I,
    arcade_input_mapper_if.slave  bus
);
    // Button index matches the joystick bit order.
    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_COIN  = 4;
    localparam int B_START = 5;

    localparam logic [23:0] COIN_LOAD = 24'(COIN_CYCLES);

    // {extended, scan code} per player, per button (right, left, down, up, coin, start).
    localparam logic [8:0] KEY_MAP [4][6] = '{
        '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h02E, 9'h016},
        '{9'h034, 9'h023, 9'h02B, 9'h02D, 9'h036, 9'h01E},
        '{9'h04B, 9'h03B, 9'h042, 9'h043, 9'h03D, 9'h026},
        '{9'h074, 9'h06B, 9'h072, 9'h075, 9'h03E, 9'h025}
    };

    logic                 old_tgl;
    logic [5:0]           key_q     [PLAYERS];
    logic [5:0]           joy_q     [PLAYERS];
    logic [23:0]          cnt       [PLAYERS];
    logic [PLAYERS-1:0]   armed;
    logic [PLAYERS-1:0]   coin_prev;

    logic                 key_event;
    logic [PLAYERS-1:0]   res_up, res_down, res_left, res_right, raw_start, raw_coin;

    // Only the six button bits of each joystick slot are consumed.
    logic unused_joy_bits;
    assign unused_joy_bits = ^bus.joystick;

    assign key_event = (bus.ps2_key[10] != old_tgl);

    always_comb begin
        res_up    = '0;
        res_down  = '0;
        res_left  = '0;
        res_right = '0;
        raw_start = '0;
        raw_coin  = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            logic [5:0] raw;
            raw          = key_q[p] | joy_q[p];
            res_left[p]  = raw[B_LEFT]  & ~(SOCD_NEUTRAL & raw[B_RIGHT]);
            res_right[p] = raw[B_RIGHT] & ~(SOCD_NEUTRAL & raw[B_LEFT]);
            res_up[p]    = raw[B_UP]    & ~(SOCD_NEUTRAL & raw[B_DOWN]);
            res_down[p]  = raw[B_DOWN]  & ~(SOCD_NEUTRAL & raw[B_UP]);
            raw_start[p] = raw[B_START];
            raw_coin[p]  = raw[B_COIN];
        end
    end

    always_ff @(posedge clk_sys) begin
        // The joystick input register is a plain pipeline stage.
        for (int p = 0; p < PLAYERS; p++) begin
            joy_q[p] <= bus.joystick[16*p +: 6];
        end
        // Tracking the toggle during reset means no spurious event on exit.
        old_tgl <= bus.ps2_key[10];

        if (!Reset_I) begin
            for (int p = 0; p < PLAYERS; p++) begin
                key_q[p] <= '0;
                cnt[p]   <= '0;
            end
            armed       <= '1;
            coin_prev   <= '0;
            bus.up_n    <= '1;
            bus.down_n  <= '1;
            bus.left_n  <= '1;
            bus.right_n <= '1;
            bus.start_n <= '1;
            bus.coin_n  <= '1;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                for (int b = 0; b < 6; b++) begin
                    if (key_event && (bus.ps2_key[8:0] == KEY_MAP[p][b])) begin
                        key_q[p][b] <= bus.ps2_key[9];
                    end
                end

                if (cnt[p] != 24'd0) begin
                    cnt[p] <= cnt[p] - 24'd1;
                end else if (armed[p]) begin
                    if (raw_coin[p] && !coin_prev[p]) begin
                        cnt[p]   <= COIN_LOAD;
                        armed[p] <= 1'b0;
                    end
                end else if (!raw_coin[p]) begin
                    armed[p] <= 1'b1;
                end
                coin_prev[p]   <= raw_coin[p];
                bus.coin_n[p]  <= (cnt[p] == 24'd0);
            end
            bus.up_n    <= ~res_up;
            bus.down_n  <= ~res_down;
            bus.left_n  <= ~res_left;
            bus.right_n <= ~res_right;
            bus.start_n <= ~raw_start;
        end
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
module tb_arcade_input_mapper;
    localparam int COIN = 8;

    logic        clk_sys = 1'b0;
    logic        Reset_I;
    logic [10:0] ps2;
    logic [63:0] joy;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper_if #(.PLAYERS(4)) bus_a ();
    arcade_input_mapper_if #(.PLAYERS(4)) bus_b ();
    arcade_input_mapper_if #(.PLAYERS(1)) bus_c ();

    assign bus_a.ps2_key  = ps2;
    assign bus_b.ps2_key  = ps2;
    assign bus_c.ps2_key  = ps2;
    assign bus_a.joystick = joy;
    assign bus_b.joystick = joy;
    assign bus_c.joystick = joy[15:0];

    arcade_input_mapper #(.PLAYERS(4), .COIN_CYCLES(COIN), .SOCD_NEUTRAL(1'b1)) u_a (
        .clk_sys(clk_sys), .Reset_I(Reset_I), .bus(bus_a.slave));
    arcade_input_mapper #(.PLAYERS(4), .COIN_CYCLES(COIN), .SOCD_NEUTRAL(1'b0)) u_b (
        .clk_sys(clk_sys), .Reset_I(Reset_I), .bus(bus_b.slave));
    arcade_input_mapper #(.PLAYERS(1), .COIN_CYCLES(COIN), .SOCD_NEUTRAL(1'b1)) u_c (
        .clk_sys(clk_sys), .Reset_I(Reset_I), .bus(bus_c.slave));

    int n_vec = 0;
    int n_err = 0;
    int a_coin_lows = 0;

    // Reference model: three configurations, four slots each.
    int   n_pl [3] = '{4, 4, 1};
    bit   socd [3] = '{1'b1, 1'b0, 1'b1};
    logic [5:0] m_key  [3][4];
    logic [5:0] m_joy  [3][4];
    bit         m_prev [3][4];
    bit         m_wait [3][4];
    int         m_left [3][4];
    logic       m_tgl  [3];
    logic [3:0] e_up [3], e_down [3], e_left [3], e_right [3], e_start [3], e_coin [3];

    // Key table: returns player*6 + button (0 right,1 left,2 down,3 up,4 coin,5 start), or -1.
    function automatic int key_lookup(logic [8:0] k);
        case (k)
            9'h174: return 0;  9'h16B: return 1;  9'h172: return 2;  9'h175: return 3;
            9'h02E: return 4;  9'h016: return 5;
            9'h034: return 6;  9'h023: return 7;  9'h02B: return 8;  9'h02D: return 9;
            9'h036: return 10; 9'h01E: return 11;
            9'h04B: return 12; 9'h03B: return 13; 9'h042: return 14; 9'h043: return 15;
            9'h03D: return 16; 9'h026: return 17;
            9'h074: return 18; 9'h06B: return 19; 9'h072: return 20; 9'h075: return 21;
            9'h03E: return 22; 9'h025: return 23;
            default: return -1;
        endcase
    endfunction

    task automatic model_edge();
        int k;
        k = key_lookup(ps2[8:0]);
        for (int d = 0; d < 3; d++) begin
            for (int p = 0; p < 4; p++) begin
                logic [5:0] raw;
                logic l, r, u, dn;
                if (p < n_pl[d]) begin
                    if (!Reset_I) begin
                        m_key[d][p]   = '0;
                        m_left[d][p]  = 0;
                        m_wait[d][p]  = 1'b0;
                        m_prev[d][p]  = 1'b0;
                        e_up[d][p]    = 1'b1;
                        e_down[d][p]  = 1'b1;
                        e_left[d][p]  = 1'b1;
                        e_right[d][p] = 1'b1;
                        e_start[d][p] = 1'b1;
                        e_coin[d][p]  = 1'b1;
                    end else begin
                        raw = m_key[d][p] | m_joy[d][p];
                        r = raw[0]; l = raw[1]; dn = raw[2]; u = raw[3];
                        if (socd[d]) begin
                            if (l && r) begin l = 1'b0; r = 1'b0; end
                            if (u && dn) begin u = 1'b0; dn = 1'b0; end
                        end
                        e_up[d][p]    = !u;
                        e_down[d][p]  = !dn;
                        e_left[d][p]  = !l;
                        e_right[d][p] = !r;
                        e_start[d][p] = !raw[5];
                        e_coin[d][p]  = (m_left[d][p] == 0);
                        if (m_left[d][p] > 0) m_left[d][p] = m_left[d][p] - 1;
                        else if (!m_wait[d][p]) begin
                            if (raw[4] && !m_prev[d][p]) begin
                                m_left[d][p] = COIN;
                                m_wait[d][p] = 1'b1;
                            end
                        end else if (!raw[4]) m_wait[d][p] = 1'b0;
                        m_prev[d][p] = raw[4];
                        if (ps2[10] != m_tgl[d] && k >= 0 && (k / 6) == p)
                            m_key[d][p][k % 6] = ps2[9];
                    end
                    m_joy[d][p] = joy[16*p +: 6];
                end
            end
            m_tgl[d] = ps2[10];
        end
    endtask

    task automatic check_model();
        logic [23:0] got, exp, mask;
        logic [3:0]  m4;
        for (int d = 0; d < 3; d++) begin
            case (d)
                0: got = {bus_a.up_n, bus_a.down_n, bus_a.left_n, bus_a.right_n, bus_a.start_n, bus_a.coin_n};
                1: got = {bus_b.up_n, bus_b.down_n, bus_b.left_n, bus_b.right_n, bus_b.start_n, bus_b.coin_n};
                default: got = {3'b0, bus_c.up_n, 3'b0, bus_c.down_n, 3'b0, bus_c.left_n,
                                3'b0, bus_c.right_n, 3'b0, bus_c.start_n, 3'b0, bus_c.coin_n};
            endcase
            m4   = (d == 2) ? 4'h1 : 4'hF;
            mask = {6{m4}};
            exp  = {e_up[d], e_down[d], e_left[d], e_right[d], e_start[d], e_coin[d]};
            n_vec++;
            if ((got & mask) !== (exp & mask)) begin
                n_err++;
                $display("FAIL model_dut%0d t=%0t got=%h exp=%h", d, $time, got & mask, exp & mask);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
        check_model();
        if (bus_a.coin_n[0] === 1'b0) a_coin_lows++;
    endtask

    task automatic send_key(input logic ext, input logic [7:0] code, input logic pressed);
        logic t;
        t   = ~ps2[10];
        ps2 = {t, pressed, ext, code};
        tick();
    endtask

    typedef struct {
        logic        ext;
        logic [7:0]  code;
        logic        pressed;
        logic [15:0] joy0;
        logic [3:0]  a_up;
        logic [1:0]  a_lr;     // {left_n[0], right_n[0]} of SOCD-neutral instance
        logic [1:0]  b_lr;     // same, pass-through instance
        logic        c_up;
        logic [3:0]  a_start;
    } vec_t;

    vec_t tbl [13];
    logic [7:0] codes [20];

    initial begin
        tbl[0]  = '{1'b1, 8'h75, 1'b1, 16'h0000, 4'b1110, 2'b11, 2'b11, 1'b0, 4'b1111};
        tbl[1]  = '{1'b0, 8'h75, 1'b1, 16'h0000, 4'b0110, 2'b11, 2'b11, 1'b0, 4'b1111};
        tbl[2]  = '{1'b1, 8'h75, 1'b0, 16'h0000, 4'b0111, 2'b11, 2'b11, 1'b1, 4'b1111};
        tbl[3]  = '{1'b0, 8'h75, 1'b0, 16'h0000, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1111};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 16'h0003, 4'b1111, 2'b11, 2'b00, 1'b1, 4'b1111};
        tbl[5]  = '{1'b1, 8'h6B, 1'b1, 16'h0001, 4'b1111, 2'b11, 2'b00, 1'b1, 4'b1111};
        tbl[6]  = '{1'b1, 8'h6B, 1'b0, 16'h0001, 4'b1111, 2'b10, 2'b10, 1'b1, 4'b1111};
        tbl[7]  = '{1'b0, 8'h16, 1'b1, 16'h0000, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1110};
        tbl[8]  = '{1'b0, 8'h16, 1'b0, 16'h0020, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1110};
        tbl[9]  = '{1'b0, 8'h1E, 1'b1, 16'h0000, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1101};
        tbl[10] = '{1'b0, 8'h1E, 1'b0, 16'h0000, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1111};
        tbl[11] = '{1'b0, 8'h2D, 1'b1, 16'h0000, 4'b1101, 2'b11, 2'b11, 1'b1, 4'b1111};
        tbl[12] = '{1'b0, 8'h2D, 1'b0, 16'h0000, 4'b1111, 2'b11, 2'b11, 1'b1, 4'b1111};
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h43, 8'h42,
                  8'h3B, 8'h4B, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

        for (int d = 0; d < 3; d++) begin
            m_tgl[d] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                m_key[d][p] = '0; m_joy[d][p] = '0; m_prev[d][p] = 1'b0;
                m_wait[d][p] = 1'b0; m_left[d][p] = 0;
            end
        end

        // Reset with the toggle bit high; release must not create an event.
        Reset_I = 1'b0;
        ps2     = 11'h400;
        joy     = '0;
        repeat (3) tick();
        Reset_I = 1'b1;
        a_coin_lows = 0;
        repeat (100) tick();
        chk("reset_coin_idle", a_coin_lows, 0);
        chk("reset_outputs_a", {bus_a.up_n, bus_a.down_n, bus_a.left_n, bus_a.right_n,
                                bus_a.start_n, bus_a.coin_n}, 24'hFFFFFF);

        for (int i = 0; i < 13; i++) begin
            joy = {48'h0, tbl[i].joy0};
            send_key(tbl[i].ext, tbl[i].code, tbl[i].pressed);
            repeat (3) tick();
            chk($sformatf("row%0d_a_up", i), bus_a.up_n, tbl[i].a_up);
            chk($sformatf("row%0d_a_lr", i), {bus_a.left_n[0], bus_a.right_n[0]}, tbl[i].a_lr);
            chk($sformatf("row%0d_b_lr", i), {bus_b.left_n[0], bus_b.right_n[0]}, tbl[i].b_lr);
            chk($sformatf("row%0d_c_up", i), bus_c.up_n, tbl[i].c_up);
            chk($sformatf("row%0d_a_start", i), bus_a.start_n, tbl[i].a_start);
        end
        joy = '0;
        repeat (4) tick();

        // Short press: one pulse of exactly COIN cycles.
        a_coin_lows = 0;
        send_key(1'b0, 8'h2E, 1'b1);
        repeat (2) tick();
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (30) tick();
        chk("coin_short_press", a_coin_lows, COIN);

        // Held coin: still one pulse; re-press gives another.
        a_coin_lows = 0;
        send_key(1'b0, 8'h2E, 1'b1);
        repeat (40) tick();
        chk("coin_held_one_pulse", a_coin_lows, COIN);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (5) tick();
        a_coin_lows = 0;
        send_key(1'b0, 8'h2E, 1'b1);
        repeat (2) tick();
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (20) tick();
        chk("coin_repress", a_coin_lows, COIN);

        // Reset in the middle of a pulse.
        send_key(1'b0, 8'h2E, 1'b1);
        begin
            int w;
            w = 0;
            while (bus_a.coin_n[0] !== 1'b0 && w < 10) begin
                tick();
                w++;
            end
        end
        chk("coin_pulse_start", bus_a.coin_n[0], 1'b0);
        repeat (3) tick();
        Reset_I = 1'b0;
        tick();
        chk("coin_reset_abort", bus_a.coin_n[0], 1'b1);
        Reset_I = 1'b1;
        a_coin_lows = 0;
        repeat (20) tick();
        chk("coin_none_after_reset", a_coin_lows, 0);
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (3) tick();
        send_key(1'b0, 8'h2E, 1'b1);
        repeat (2) tick();
        send_key(1'b0, 8'h2E, 1'b0);
        repeat (20) tick();
        chk("coin_after_reset_repress", a_coin_lows, COIN);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Reset_I = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0)
                joy = {$urandom, $urandom} & {$urandom, $urandom} & 64'h003F_003F_003F_003F;
            if ($urandom_range(0, 2) == 0) begin
                logic t;
                logic [7:0] c;
                c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 19)];
                t = ~ps2[10];
                ps2 = {t, 1'($urandom), 1'($urandom), c};
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
